csl_seq: RTL and testbench

Console command sequencer in front of the CPU console-status interface (cpuRUN/cpuCONT/cpuEXEC/cpuHALT). It accepts one host command at a time (RUN, HALT, STEP, EXEC) and drives the cslSET/cslRUN/cslCONT/cslEXEC strobe set. It then waits for the microcode to acknowledge through the cpu* status lines, and reports completion with a status code. It sits between the console bus register file and the CPU console interface.

---
 rtl/csl_seq_pkg.sv | 74 +++++++
 rtl/csl_seq_timer.sv | 39 +++
 rtl/csl_seq.sv | 156 +++++++++++++++
 tb/tb_csl_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/csl_seq_pkg.sv
// Shared types and command tables for the console command sequencer.
// Optional feature macro: CSL_SEQ_TIMEOUT_EN (WAIT-state timeout).
package csl_seq_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_RUN  = 3'd1,
        CMD_HALT = 3'd2,
        CMD_STEP = 3'd3,
        CMD_EXEC = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        STAT_OK      = 3'd0,
        STAT_TIMEOUT = 3'd1,
        STAT_ILLEGAL = 3'd2,
        STAT_NOTHALT = 3'd3,
        STAT_ABORT   = 3'd4
    } stat_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SET   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic run;
        logic cont;
        logic exec;
    } csl_t;

    localparam int unsigned TIMER_W = 16;

    function automatic logic cmd_legal(input logic [2:0] code);
        return (code <= CMD_EXEC);
    endfunction

    // STEP and EXEC are only meaningful on a halted CPU.
    function automatic logic cmd_needs_halt(input logic [2:0] code);
        return (code == CMD_STEP) || (code == CMD_EXEC);
    endfunction

    function automatic csl_t csl_lookup(input logic [2:0] code);
        csl_t v;
        v = '0;
        case (code)
            CMD_RUN:  v = '{run: 1'b1, cont: 1'b1, exec: 1'b0};
            CMD_STEP: v = '{run: 1'b0, cont: 1'b1, exec: 1'b0};
            CMD_EXEC: v = '{run: 1'b0, cont: 1'b1, exec: 1'b1};
            default:  v = '0;
        endcase
        return v;
    endfunction

    function automatic logic cmd_complete(input logic [2:0] code,
                                          input logic       cont,
                                          input logic       exec,
                                          input logic       halt);
        logic met;
        met = 1'b0;
        case (code)
            CMD_RUN:  met = !halt;
            CMD_HALT: met = halt;
            CMD_STEP: met = halt && !cont;
            CMD_EXEC: met = halt && !cont && !exec;
            default:  met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/csl_seq_timer.sv
// Saturating 16-bit WAIT-state timer with synchronous clear and a terminal-count flag.
// Only instantiated when CSL_SEQ_TIMEOUT_EN is defined.
module csl_seq_timer
    import csl_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clken,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clken) begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/csl_seq.sv
// Console command sequencer: accepts one host command, strobes the console status
// flops, waits for the microcode handshake and reports a status. Macro: CSL_SEQ_TIMEOUT_EN.
module csl_seq
    import csl_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clken,
    input  logic       cmdVALID,
    input  logic [2:0] cmdCODE,
    input  logic       cmdABORT,
    output logic       cmdREADY,
    output logic       cmdDONE,
    output logic [2:0] cmdSTAT,
    input  logic       cpuRUN,
    input  logic       cpuCONT,
    input  logic       cpuEXEC,
    input  logic       cpuHALT,
    output logic       cslSET,
    output logic       cslRUN,
    output logic       cslCONT,
    output logic       cslEXEC
);

    state_e     state_q, state_d;
    logic [2:0] cmd_q, cmd_d;
    stat_e      stat_q, stat_d;
    csl_t       csl_q, csl_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       set_q, set_d;

    // Completion never depends on the CPU run flag; it is part of the interface only.
    logic unused_cpu_run;
    assign unused_cpu_run = cpuRUN;

`ifdef CSL_SEQ_TIMEOUT_EN
    logic tmr_clr, tmr_inc, tmr_expire;

    csl_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clken    (clken),
        .clr_i    (tmr_clr),
        .inc_i    (tmr_inc),
        .expire_o (tmr_expire)
    );
`else
    logic [TIMER_W-1:0] unused_timeout;
    assign unused_timeout = TIMER_W'(TIMEOUT);
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        stat_d  = stat_q;
        csl_d   = csl_q;
`ifdef CSL_SEQ_TIMEOUT_EN
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmdVALID) begin
                    cmd_d   = cmdCODE;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!cmd_legal(cmd_q)) begin
                    stat_d  = STAT_ILLEGAL;
                    state_d = ST_DONE;
                end else if (cmd_needs_halt(cmd_q) && !cpuHALT) begin
                    stat_d  = STAT_NOTHALT;
                    state_d = ST_DONE;
                end else if (cmd_q == CMD_NOP) begin
                    stat_d  = STAT_OK;
                    state_d = ST_DONE;
                end else begin
                    csl_d   = csl_lookup(cmd_q);
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
`ifdef CSL_SEQ_TIMEOUT_EN
                tmr_clr = 1'b1;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Priority: completion, then abort, then timeout.
                if (cmd_complete(cmd_q, cpuCONT, cpuEXEC, cpuHALT)) begin
                    stat_d  = STAT_OK;
                    state_d = ST_DONE;
                end else if (cmdABORT) begin
                    stat_d  = STAT_ABORT;
                    state_d = ST_DONE;
`ifdef CSL_SEQ_TIMEOUT_EN
                end else if (tmr_expire) begin
                    stat_d  = STAT_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    tmr_inc = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DONE) begin
            csl_d = '0;
        end

        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        set_d   = (state_d == ST_SET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            stat_q  <= STAT_OK;
            csl_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            set_q   <= 1'b0;
        end else if (clken) begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            stat_q  <= stat_d;
            csl_q   <= csl_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            set_q   <= set_d;
        end
    end

    assign cmdREADY = ready_q;
    assign cmdDONE  = done_q;
    assign cmdSTAT  = stat_q;
    assign cslSET   = set_q;
    assign cslRUN   = csl_q.run;
    assign cslCONT  = csl_q.cont;
    assign cslEXEC  = csl_q.exec;

endmodule

// File: tb/tb_csl_seq.sv
// Self-checking bench for csl_seq: transaction-level reference model predicts strobe
// timing, held data, completion cycle and status for each command.
`timescale 1ns/1ps
module tb_csl_seq;

    localparam int TO    = 16;
    localparam int NEVER = 1000000;
`ifdef CSL_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clken = 1'b1;
    logic       cmdVALID = 1'b0;
    logic [2:0] cmdCODE = 3'd0;
    logic       cmdABORT = 1'b0;
    logic       cpuRUN = 1'b0, cpuCONT = 1'b0, cpuEXEC = 1'b0, cpuHALT = 1'b0;
    logic       cmdREADY, cmdDONE, cslSET, cslRUN, cslCONT, cslEXEC;
    logic [2:0] cmdSTAT;

    csl_seq #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clken    (clken),
        .cmdVALID (cmdVALID),
        .cmdCODE  (cmdCODE),
        .cmdABORT (cmdABORT),
        .cmdREADY (cmdREADY),
        .cmdDONE  (cmdDONE),
        .cmdSTAT  (cmdSTAT),
        .cpuRUN   (cpuRUN),
        .cpuCONT  (cpuCONT),
        .cpuEXEC  (cpuEXEC),
        .cpuHALT  (cpuHALT),
        .cslSET   (cslSET),
        .cslRUN   (cslRUN),
        .cslCONT  (cslCONT),
        .cslEXEC  (cslEXEC)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: outcome of one command, counted in clken cycles from the accept cycle (t=0).
    // k = WAIT index at which the completion pattern appears, a = WAIT index of cmdABORT.
    task automatic model(input int code, input bit halt_ok, input int k, input int a,
                         output bit has_set, output int stat, output int done,
                         output logic [2:0] vals);
        int to_idx;
        int e;
        has_set = 1'b0;
        vals    = 3'b000;
        to_idx  = TO_EN ? TO - 1 : NEVER;
        if (code > 4) begin
            stat = 2; done = 2;
        end else if ((code == 3 || code == 4) && !halt_ok) begin
            stat = 3; done = 2;
        end else if (code == 0) begin
            stat = 0; done = 2;
        end else begin
            has_set = 1'b1;
            case (code)
                1:       vals = 3'b110;
                3:       vals = 3'b010;
                4:       vals = 3'b011;
                default: vals = 3'b000;
            endcase
            if (k <= a && k <= to_idx) begin
                stat = 0; e = k;
            end else if (a <= to_idx) begin
                stat = 4; e = a;
            end else begin
                stat = 1; e = to_idx;
            end
            done = 4 + e;
        end
    endtask

    // CPU status lines: "comp" selects a pattern satisfying the completion rule for code.
    task automatic drive_cpu(input int code, input bit halt_ok, input bit comp);
        logic [2:0] r;
        r = 3'($urandom);
        cpuRUN = r[0];
        case (code)
            1: begin cpuCONT = r[1]; cpuEXEC = r[2]; cpuHALT = !comp; end
            2: begin cpuCONT = r[1]; cpuEXEC = r[2]; cpuHALT = comp;  end
            3: begin cpuHALT = halt_ok; cpuEXEC = r[2]; cpuCONT = halt_ok ? !comp : r[1]; end
            4: begin
                cpuHALT = halt_ok;
                if (comp && halt_ok) begin
                    cpuCONT = 1'b0; cpuEXEC = 1'b0;
                end else if (r[2:1] == 2'b00) begin
                    cpuCONT = 1'b0; cpuEXEC = 1'b1;
                end else begin
                    cpuCONT = r[1]; cpuEXEC = r[2];
                end
            end
            default: begin cpuCONT = r[1]; cpuEXEC = r[2]; cpuHALT = $urandom_range(0, 1) == 1; end
        endcase
    endtask

    task automatic run_cmd(input int code, input bit halt_ok, input int k, input int a,
                           input bit slow_en);
        bit         has_set;
        int         stat, done, t, guard;
        logic [2:0] vals;
        model(code, halt_ok, k, a, has_set, stat, done, vals);
        t = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            chk("ready", cmdREADY, (t == 0 || t == done + 1));
            chk("done",  cmdDONE,  (t == done));
            chk("set",   cslSET,   (has_set && t == 2));
            chk("csl",   {cslRUN, cslCONT, cslEXEC},
                (has_set && t >= 2 && t < done) ? vals : 3'b000);
            if (t >= done) chk("stat", cmdSTAT, stat);
            if (t == done + 1) break;
            cmdVALID = (t == 0) ? 1'b1 : ((t < done) ? ($urandom_range(0, 1) == 1) : 1'b0);
            cmdCODE  = (t == 0) ? 3'(code) : 3'($urandom);
            cmdABORT = (t == 3 + a) || ((t < 3 || t >= done) && ($urandom_range(0, 1) == 1));
            drive_cpu(code, halt_ok, (t >= 3 + k));
            clken = slow_en ? ($urandom_range(0, 2) == 0) : 1'b1;
            @(posedge clk);
            if (clken) t++;
            guard++;
            if (guard > 20000) begin
                chk("cycle_budget", 32'(guard), 32'd0);
                break;
            end
        end
        cmdVALID = 1'b0;
        cmdABORT = 1'b0;
        clken    = 1'b1;
    endtask

    initial begin
        int code, k, a;
        bit halt_ok, slow;

        // Reset state
        clken = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmdREADY, 1);
        chk("rst_done",  cmdDONE,  0);
        chk("rst_set",   cslSET,   0);
        chk("rst_csl",   {cslRUN, cslCONT, cslEXEC}, 0);
        chk("rst_stat",  cmdSTAT,  0);
        rst_n = 1'b1;

        run_cmd(2, 1'b1, 0, NEVER, 1'b0);        // HALT, immediate completion
        run_cmd(1, 1'b1, 4, NEVER, 1'b0);        // RUN, halt drops later
        run_cmd(3, 1'b0, 0, NEVER, 1'b0);        // STEP on running CPU
        run_cmd(6, 1'b1, 0, NEVER, 1'b0);        // illegal code
        run_cmd(0, 1'b1, 0, NEVER, 1'b0);        // NOP
        run_cmd(4, 1'b1, 0, NEVER, 1'b0);        // EXEC, completes at once
        run_cmd(4, 1'b1, NEVER, TO_EN ? NEVER : 1000, 1'b0);  // EXEC stuck

        // Reset in the middle of WAIT
        @(negedge clk);
        cmdVALID = 1'b1; cmdCODE = 3'd1; cpuHALT = 1'b1;
        @(negedge clk);
        cmdVALID = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", cmdREADY, 0);
        chk("csl_before_rst",  {cslRUN, cslCONT, cslEXEC}, 3'b110);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", cmdREADY, 1);
        chk("midrst_set",   cslSET,   0);
        chk("midrst_csl",   {cslRUN, cslCONT, cslEXEC}, 0);
        chk("midrst_done",  cmdDONE,  0);
        chk("midrst_stat",  cmdSTAT,  0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(2, 1'b1, 0, NEVER, 1'b0);        // accepted normally after reset
        run_cmd(3, 1'b1, 3, 3, 1'b0);            // completion beats abort
        run_cmd(1, 1'b1, NEVER, 5, 1'b0);        // abort
        run_cmd(1, 1'b1, 6, NEVER, 1'b1);        // RUN with sparse clken

        for (int i = 0; i < 150; i++) begin
            code    = $urandom_range(0, 7);
            halt_ok = ($urandom_range(0, 3) != 0);
            k       = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, 25);
            a       = ($urandom_range(0, 1) == 0) ? NEVER : $urandom_range(0, 40);
            if (!TO_EN && k == NEVER && a == NEVER) a = 30;
            slow    = ($urandom_range(0, 3) == 0);
            run_cmd(code, halt_ok, k, a, slow);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
